// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared encodings and register map for the multi-channel PWM
package pwm_pkg;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

    localparam int ADDR_TOP   = 0;
    localparam int ADDR_PRESC = 1;
    localparam int ADDR_MODE  = 2;
    localparam int ADDR_POL   = 3;
    localparam int ADDR_DUTY0 = 4;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM output: compare against the shared counter, apply polarity, register
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    input  logic             pol,
    output logic             pwm_out
);

    // While stopped the raw level is forced inactive so the pin rests at its polarity.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (en && (cnt < duty)) ^ pol;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shadowed configuration and edge/center counting
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS)+2:0] cfg_addr,
    input  logic [WIDTH-1:0]            cfg_wdata,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic                        cycle_start
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]   top_sh, top_a;
    logic [PRESC_W-1:0] presc_sh, presc_a;
    pwm_mode_e          mode_sh, mode_a;
    logic [CHANNELS-1:0] pol_sh, pol_a;
    logic [WIDTH-1:0]   duty_sh [CHANNELS];
    logic [WIDTH-1:0]   duty_a  [CHANNELS];

    logic [PRESC_W-1:0] psc, psc_nxt;
    logic [WIDTH-1:0]   cnt, cnt_nxt;
    logic               dir_down, dir_down_nxt;
    logic               tick, boundary;
    int                 addr_i;

    always_comb addr_i = int'(cfg_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            top_sh   <= '0;
            presc_sh <= '0;
            mode_sh  <= EDGE;
            pol_sh   <= '0;
            for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= '0;
        end else if (cfg_we) begin
            if (addr_i == ADDR_TOP)   top_sh   <= cfg_wdata;
            if (addr_i == ADDR_PRESC) presc_sh <= PRESC_W'(cfg_wdata);
            if (addr_i == ADDR_MODE)  mode_sh  <= pwm_mode_e'(cfg_wdata[0]);
            if (addr_i == ADDR_POL)   pol_sh   <= CHANNELS'(cfg_wdata);
            for (int i = 0; i < CHANNELS; i++) begin
                if (addr_i == ADDR_DUTY0 + i) duty_sh[i] <= cfg_wdata;
            end
        end
    end

    // Active copies read the pre-write shadow, so a write on the boundary cycle waits a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_a   <= '0;
            presc_a <= '0;
            mode_a  <= EDGE;
            pol_a   <= '0;
            for (int i = 0; i < CHANNELS; i++) duty_a[i] <= '0;
        end else if (!en || boundary) begin
            top_a   <= top_sh;
            presc_a <= presc_sh;
            mode_a  <= mode_sh;
            pol_a   <= pol_sh;
            duty_a  <= duty_sh;
        end
    end

    always_comb begin
        tick         = en && (psc >= presc_a);
        boundary     = 1'b0;
        psc_nxt      = psc;
        cnt_nxt      = cnt;
        dir_down_nxt = dir_down;
        if (!en) begin
            psc_nxt      = '0;
            cnt_nxt      = '0;
            dir_down_nxt = 1'b0;
        end else if (!tick) begin
            psc_nxt = psc + 1'b1;
        end else begin
            psc_nxt = '0;
            if (mode_a == EDGE) begin
                if (cnt >= top_a) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (top_a == '0) begin
                cnt_nxt      = '0;
                dir_down_nxt = 1'b0;
                boundary     = 1'b1;
            end else if (!dir_down) begin
                // Center period starts on the tick that leaves zero going up.
                boundary = (cnt == '0);
                if (cnt >= top_a) begin
                    cnt_nxt      = cnt - 1'b1;
                    dir_down_nxt = (cnt > ONE);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (cnt <= ONE) begin
                cnt_nxt      = '0;
                dir_down_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
            if (boundary && (mode_sh != mode_a)) begin
                cnt_nxt      = '0;
                dir_down_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc         <= '0;
            cnt         <= '0;
            dir_down    <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            psc         <= psc_nxt;
            cnt         <= cnt_nxt;
            dir_down    <= dir_down_nxt;
            cycle_start <= boundary;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .cnt     (cnt),
            .duty    (duty_a[g]),
            .pol     (pol_a[g]),
            .pwm_out (pwm_out[g])
        );
    end

endmodule
